// File: rtl/fwd_pattern_gen.sv
// Forwarding-select generator that sits beside the ID/EX pipeline register.
// It tracks the destinations of the two older in-flight instructions (EX, MEM)
// and registers a 2-bit operand-select code per source as the ID instruction
// advances into EX:
//   0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
module fwd_pattern_gen #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_write,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_ex_valid
);

  // Tracker: the instruction now in EX and the one now in MEM.
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_we;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_we;

  // Registered outputs.
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic       r_ex_valid;

  logic       w_slot_valid;
  logic       w_slot_we;
  logic [1:0] w_code_a;
  logic [1:0] w_code_b;

  // The nearest older producer wins; register 0 never forwards.
  function automatic logic [1:0] sel_code(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] ex_rd,
    input logic              ex_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic              mem_we
  );
    logic [1:0] code;
    code = 2'd0;
    if (src != '0) begin
      if (ex_we && (ex_rd == src)) begin
        code = 2'd1;
      end else if (mem_we && (mem_rd == src)) begin
        code = 2'd2;
      end
    end
    return code;
  endfunction

  // Next-state codes from the current tracker and the ID instruction.
  always_comb begin
    w_slot_valid = i_id_valid & ~i_flush;
    w_slot_we    = w_slot_valid & i_id_reg_write;
    w_code_a     = 2'd0;
    w_code_b     = 2'd0;
    if (w_slot_valid) begin
      w_code_a = sel_code(i_id_rs1, r_ex_rd, r_ex_we, r_mem_rd, r_mem_we);
      w_code_b = sel_code(i_id_rs2, r_ex_rd, r_ex_we, r_mem_rd, r_mem_we);
    end
  end

  // Tracker shift and output registers; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd    <= '0;
      r_ex_we    <= 1'b0;
      r_mem_rd   <= '0;
      r_mem_we   <= 1'b0;
      r_fwd_a    <= 2'd0;
      r_fwd_b    <= 2'd0;
      r_ex_valid <= 1'b0;
    end else if (!i_stall) begin
      r_mem_rd   <= r_ex_rd;
      r_mem_we   <= r_ex_we;
      r_ex_rd    <= i_id_rd;
      r_ex_we    <= w_slot_we;
      r_fwd_a    <= w_code_a;
      r_fwd_b    <= w_code_b;
      r_ex_valid <= w_slot_valid;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    o_fwd_a    = r_fwd_a;
    o_fwd_b    = r_fwd_b;
    o_ex_valid = r_ex_valid;
  end

endmodule

// File: tb/tb_fwd_pattern_gen.sv
// Scoreboard bench for fwd_pattern_gen: the driver advances a history-list
// model on every edge and queues the expected outputs; a monitor pops and
// compares them on each falling edge.
module tb_fwd_pattern_gen;

  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          stall;
  logic          flush;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          ex_valid;

  fwd_pattern_gen #(.REG_AW(AW)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_id_valid     (id_valid),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_rd        (id_rd),
    .i_id_reg_write (id_reg_write),
    .i_stall        (stall),
    .i_flush        (flush),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_ex_valid     (ex_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          we;
  } slot_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       v;
  } exp_t;

  // hist[0] is the youngest advanced instruction (in EX), hist[1] is in MEM.
  slot_t hist[$];
  exp_t  exp_q[$];
  exp_t  cur;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Code for one source: search older instructions youngest first.
  function automatic logic [1:0] model_code(input logic [AW-1:0] s);
    if (s == 0) return 2'd0;
    for (int i = 0; i < hist.size() && i < 2; i++) begin
      if (hist[i].we && hist[i].rd == s) return 2'(i + 1);
    end
    return 2'd0;
  endfunction

  // Called at each rising edge with the inputs that were sampled there.
  task automatic model_edge();
    exp_t  nx;
    slot_t s;
    if (!stall) begin
      nx.v = id_valid && !flush;
      nx.a = nx.v ? model_code(id_rs1) : 2'd0;
      nx.b = nx.v ? model_code(id_rs2) : 2'd0;
      s.rd = id_rd;
      s.we = nx.v && id_reg_write;
      hist.push_front(s);
      while (hist.size() > 2) void'(hist.pop_back());
      cur = nx;
    end
    exp_q.push_back(cur);
  endtask

  // Drive one cycle from a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input int rs1, input int rs2, input int rd,
                      input logic we, input logic st, input logic fl);
    id_valid     = v;
    id_rs1       = AW'(rs1);
    id_rs2       = AW'(rs2);
    id_rd        = AW'(rd);
    id_reg_write = we;
    stall        = st;
    flush        = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic instr(input int rs1, input int rs2, input int rd, input logic we);
    step(1'b1, rs1, rs2, rd, we, 1'b0, 1'b0);
  endtask

  task automatic bubble();
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_model();
    hist.delete();
    exp_q.delete();
    cur = '0;
  endtask

  // Monitor: compare registered outputs against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_fwd_a", int'(fwd_a), int'(e.a));
      check("sb_fwd_b", int'(fwd_b), int'(e.b));
      check("sb_ex_valid", int'(ex_valid), int'(e.v));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_reg_write = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_model();
    #1;
    check("reset_fwd_a", int'(fwd_a), 0);
    check("reset_fwd_b", int'(fwd_b), 0);
    check("reset_ex_valid", int'(ex_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back dependency.
    instr(0, 0, 5, 1'b1);
    instr(5, 7, 1, 1'b0);
    check("b2b_fwd_a", int'(fwd_a), 1);
    check("b2b_fwd_b", int'(fwd_b), 0);
    check("b2b_ex_valid", int'(ex_valid), 1);

    // Distance two and priority.
    instr(0, 0, 3, 1'b1);
    instr(0, 0, 9, 1'b1);
    instr(3, 9, 0, 1'b0);
    check("dist2_fwd_a", int'(fwd_a), 2);
    check("dist2_fwd_b", int'(fwd_b), 1);
    instr(0, 0, 3, 1'b1);
    instr(0, 0, 3, 1'b1);
    instr(3, 0, 0, 1'b0);
    check("prio_fwd_a", int'(fwd_a), 1);

    // Register zero and non-writers.
    instr(0, 0, 0, 1'b1);
    instr(0, 0, 0, 1'b0);
    check("x0_fwd_a", int'(fwd_a), 0);
    instr(0, 0, 4, 1'b0);
    instr(4, 0, 0, 1'b0);
    check("nowe_fwd_a", int'(fwd_a), 0);

    // Self-dependency does not forward.
    bubble(); bubble();
    instr(12, 0, 12, 1'b1);
    check("self_fwd_a", int'(fwd_a), 0);

    // Stall hold.
    instr(0, 0, 6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 6, 0, 1'b0, 1'b1, 1'b0);
      check("stall_hold_fwd_b", int'(fwd_b), 0);
      check("stall_hold_valid", int'(ex_valid), 1);
    end
    step(1'b1, 0, 6, 0, 1'b0, 1'b0, 1'b0);
    check("stall_release_fwd_b", int'(fwd_b), 1);

    // Flush: the flushed slot becomes a bubble and never forwards.
    step(1'b1, 0, 0, 8, 1'b1, 1'b0, 1'b1);
    check("flush_ex_valid", int'(ex_valid), 0);
    instr(8, 8, 0, 1'b0);
    check("flush_fwd_a", int'(fwd_a), 0);
    check("flush_fwd_b", int'(fwd_b), 0);

    // Flush together with stall changes nothing.
    instr(0, 0, 10, 1'b1);
    step(1'b1, 10, 0, 11, 1'b1, 1'b1, 1'b1);
    check("flush_stall_valid", int'(ex_valid), 1);
    check("flush_stall_fwd_a", int'(fwd_a), 0);
    instr(10, 0, 0, 1'b0);
    check("after_flush_stall_fwd_a", int'(fwd_a), 1);

    // Mid-stream asynchronous reset.
    instr(0, 0, 13, 1'b1);
    instr(13, 13, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_fwd_a", int'(fwd_a), 0);
    check("async_rst_fwd_b", int'(fwd_b), 0);
    check("async_rst_ex_valid", int'(ex_valid), 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    instr(0, 0, 13, 1'b1);
    clear_model();
    hist.push_front('{rd: AW'(13), we: 1'b1});
    cur = '{a: 2'd0, b: 2'd0, v: 1'b1};
    // A pre-reset producer of r13 must not be seen by the next instruction
    // besides the one just issued after release; check a distance-two case.
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    instr(13, 0, 0, 1'b0);
    check("post_rst_dist2_fwd_a", int'(fwd_a), 2);
    rst_n = 1'b0;
    #1;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    instr(13, 13, 0, 1'b0);
    check("post_rst_fwd_a", int'(fwd_a), 0);
    check("post_rst_fwd_b", int'(fwd_b), 0);

    // Randomised traffic on a small register window to force hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7),
           $urandom_range(7), $urandom_range(1), $urandom_range(99) < 20,
           $urandom_range(99) < 10);
    end
    bubble();
    bubble();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_pattern_gen.md
# fwd_pattern_gen

Sequential producer of the 2-bit operand-select patterns that the datapath's pattern decoders consume: code 1 selects the EX/MEM result, code 2 selects the MEM/WB result, and code 0 selects the register-file value. The block sits beside the ID/EX pipeline register of the RISC core. It tracks the destination registers of the two older in-flight instructions and registers one select code per source operand. The codes become valid in the same cycle the instruction enters EX.

## Interface
Parameters:
- REG_AW, 5, register-address width; register 0 is hard-wired zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  a real instruction is in ID.
- id_rs1  in  REG_AW  source register A of the ID instruction.
- id_rs2  in  REG_AW  source register B of the ID instruction.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes id_rd.
- stall  in  1  freeze: hold all internal state and outputs.
- flush  in  1  replace the advancing ID instruction with a bubble.
- fwd_a  out  2  select pattern for EX operand A (0 = RF, 1 = EX/MEM, 2 = MEM/WB).
- fwd_b  out  2  select pattern for EX operand B, same encoding.
- ex_valid  out  1  the EX-stage slot holds a real instruction.

## Operation
- Internal tracker: ex_rd/ex_we describe the instruction now in EX (next cycle in MEM). mem_rd/mem_we describe the instruction now in MEM (next cycle in WB).
- An advance is any rising edge with stall=0.
- On advance, the tracker shifts:
  - mem_rd <= ex_rd and mem_we <= ex_we.
  - ex_rd <= id_rd.
  - ex_we <= id_valid & id_reg_write & ~flush.
  - ex_valid <= id_valid & ~flush.
- Code computation is combinational from the current tracker and ID inputs, and is registered on advance. For each source s in {id_rs1, id_rs2}:
  - If s == 0, the code is 0.
  - Otherwise, if ex_we and ex_rd == s, the code is 1 (nearest producer wins).
  - Otherwise, if mem_we and mem_rd == s, the code is 2.
  - Otherwise, the code is 0.
- If id_valid=0 or flush=1 on the advance, both codes are registered as 0.
- Code 3 is never produced; the consumer treats 3 as 0.
- Stall=1: tracker, fwd_a, fwd_b and ex_valid all hold their values. The ID inputs are ignored.
- flush=1 together with stall=1: stall wins and nothing changes. The flush must be reasserted on the first unstalled cycle.
- An instruction whose rd equals its own rs does not forward to itself; comparison is only against older instructions.

## Timing
- Reset (rst_n=0, asynchronous): fwd_a=0, fwd_b=0, ex_valid=0, ex_we=0, mem_we=0, ex_rd=0, mem_rd=0. Outputs are 0 immediately, without waiting for a clock edge.
- Reset deassertion is synchronised externally; the first advance may occur on the first edge after release.
- Latency: ID inputs sampled at advance edge N produce fwd_a/fwd_b/ex_valid valid from edge N until the next advance edge.
- Outputs are pure register outputs with no combinational path from the inputs.
- Reset asserted mid-stream discards every in-flight entry. Codes are 0 after reset, even if a dependent instruction follows.
- Bubbles: a flushed or invalid slot has we=0, so it never becomes a forwarding source in either stage.
- Throughput: one instruction per unstalled cycle. Any number of consecutive stalls is allowed.

## Test plan
- Reset: drive traffic, then pull rst_n low between edges -> fwd_a=fwd_b=0 and ex_valid=0 at once. After release, an instruction with rs1=rd of the pre-reset instruction gets fwd_a=0.
- Back-to-back dependency: I1 (rd=5, we=1), then I2 (rs1=5, rs2=7) -> while I2 is in EX, fwd_a=1 and fwd_b=0.
- Distance-two with priority: I1 (rd=3), I2 (rd=9), I3 (rs1=3, rs2=9) -> fwd_a=2, fwd_b=1. Repeat with I1 and I2 both rd=3 and I3 rs1=3 -> fwd_a=1.
- Register zero and non-writers: I1 (rd=0, we=1), I2 (rs1=0) -> fwd_a=0. I1 (rd=4, we=0), I2 (rs1=4) -> fwd_a=0.
- Stall hold: I1 (rd=6), then I2 (rs2=6) with stall=1 for 3 cycles -> outputs and tracker unchanged during the stall. On the first unstalled edge, fwd_b=1.
- Flush: I1 (rd=8) is flushed on advance, then I2 (rs1=8) -> ex_valid=0 in the bubble cycle, and fwd_a=0 for I2. Also check that flush+stall together changes nothing.
